// File: rtl/axi_write_master_pkg.sv
// Shared AXI4 encodings for the write bridge and its slave counterpart.
package axi_write_master_pkg;

   localparam logic [1:0] RSP_OKAY   = 2'b00;
   localparam logic [1:0] RSP_EXOKAY = 2'b01;
   localparam logic [1:0] RSP_SLVERR = 2'b10;
   localparam logic [1:0] RSP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AxSIZE encoding for a full-width beat
   function automatic logic [2:0] axsize(int dw);
      return 3'($clog2(dw / 8));
   endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// AXI4 write-only channel bundle (AW, W, B) with master/slave views.
interface axi_write_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1
);
   logic                    awready;
   logic                    awvalid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [ID_WIDTH-1:0]     awid;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    wready;
   logic                    wvalid;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    bready;
   logic                    bvalid;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;

   modport master (
      input  awready, output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wready,  output wvalid, wdata, wstrb, wlast,
      output bready,  input  bvalid, bid, bresp
   );

   modport slave (
      output awready, input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output wready,  input  wvalid, wdata, wstrb, wlast,
      input  bready,  output bvalid, bid, bresp
   );
endinterface

// File: rtl/axi_write_master_burst_buffer.sv
// Burst staging storage: one synchronous write port, one asynchronous read port.
module axi_write_master_burst_buffer #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents need no reset: a burst is always written before it is read.
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/axi_write_master.sv
// Stream-to-AXI write bridge: buffers up to BURST_LEN beats, then issues one
// FIXED burst to a single address and checks the B response.
module axi_write_master
   import axi_write_master_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ID_WIDTH   = 1,
   parameter logic [ADDR_WIDTH-1:0] ADDRESS    = '0,
   parameter logic [ID_WIDTH-1:0]   AXI_ID     = '0,
   parameter int                    BURST_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  input_ready,
   input  logic                  input_valid,
   input  logic [DATA_WIDTH-1:0] input_data,
   input  logic                  input_last,
   axi_write_master_if.master    m_axi,
   output logic                  busy,
   output logic                  resp_error,
   output logic [15:0]           error_count
);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {FILL, SEND, RESP} state_t;

   state_t                state;
   logic [CW-1:0]         count, rd_ptr, count_nxt;
   logic [7:0]            awlen;
   logic                  aw_done, w_done;
   logic                  awvalid, wvalid, bready;
   logic                  accept, aw_hs, w_hs, last_hs, b_hs, wlast, bad_rsp;
   logic [DATA_WIDTH-1:0] rd_data;

   assign input_ready = reset && (state == FILL);
   assign accept      = input_valid && input_ready;
   assign count_nxt   = count + 1'b1;
   assign wlast       = 9'(rd_ptr) == {1'b0, awlen};
   assign aw_hs       = awvalid && m_axi.awready;
   assign w_hs        = wvalid && m_axi.wready;
   assign last_hs     = w_hs && wlast;
   assign b_hs        = bready && m_axi.bvalid;
   assign bad_rsp     = (m_axi.bresp != RSP_OKAY) || (m_axi.bid != AXI_ID);

   axi_write_master_burst_buffer #(
      .DEPTH      (BURST_LEN),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
   ) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (count[AW-1:0]),
      .wdata (input_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FILL;
         count       <= '0;
         rd_ptr      <= '0;
         awlen       <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         bready      <= 1'b0;
         resp_error  <= 1'b0;
         error_count <= '0;
      end else begin
         resp_error <= 1'b0;
         case (state)
            FILL: if (accept) begin
               count <= count_nxt;
               if (count_nxt == CW'(BURST_LEN) || input_last) begin
                  state   <= SEND;
                  awlen   <= 8'(count_nxt - 1'b1);
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
               end
            end
            SEND: begin
               if (aw_hs) begin
                  aw_done <= 1'b1;
                  awvalid <= 1'b0;
               end
               if (w_hs) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (wlast) begin
                     w_done <= 1'b1;
                     wvalid <= 1'b0;
                  end
               end
               // W may finish before AW; wait for both before accepting B
               if ((aw_done || aw_hs) && (w_done || last_hs)) begin
                  state  <= RESP;
                  bready <= 1'b1;
               end
            end
            RESP: if (b_hs) begin
               state      <= FILL;
               bready     <= 1'b0;
               count      <= '0;
               rd_ptr     <= '0;
               aw_done    <= 1'b0;
               w_done     <= 1'b0;
               resp_error <= bad_rsp;
               if (bad_rsp && error_count != 16'hFFFF)
                  error_count <= error_count + 16'd1;
            end
            default: state <= FILL;
         endcase
      end
   end

   assign busy = (state != FILL) || (count != '0);

   assign m_axi.awvalid = awvalid;
   assign m_axi.awaddr  = ADDRESS;
   assign m_axi.awid    = AXI_ID;
   assign m_axi.awlen   = awlen;
   assign m_axi.awsize  = axsize(DATA_WIDTH);
   assign m_axi.awburst = BURST_FIXED;
   assign m_axi.wvalid  = wvalid;
   assign m_axi.wdata   = rd_data;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wlast;
   assign m_axi.bready  = bready;
endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: a scripted AXI slave records handshakes and
// checks channel stability; bursts are compared against queued beat data.
module tb_axi_write_master;
   localparam int          BL   = 4;
   localparam logic [31:0] ADDR = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        input_ready, busy, resp_error;
   logic        input_valid = 1'b0, input_last = 1'b0;
   logic [31:0] input_data = '0;
   logic [15:0] error_count;

   always #5 clk = ~clk;

   axi_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) bus ();

   axi_write_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1),
      .ADDRESS(ADDR), .AXI_ID(1'b0), .BURST_LEN(BL)
   ) dut (
      .clk(clk), .reset(rst_n),
      .input_ready(input_ready), .input_valid(input_valid),
      .input_data(input_data), .input_last(input_last),
      .m_axi(bus),
      .busy(busy), .resp_error(resp_error), .error_count(error_count)
   );

   int checks = 0, errors = 0;
   int exp_err = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slave knobs and what it saw
   int          aw_hold = 0, b_delay = 0;
   bit          w_toggle = 0;
   logic [1:0]  b_resp = 2'b00;
   logic        b_id = 1'b0;
   logic [7:0]  aw_q[$];
   logic [31:0] wd_q[$];
   bit          wl_q[$];
   int          b_hs_cnt = 0;
   bit          wlast_before_aw = 0;

   // Slave: at each falling edge set readies for the coming rising edge and
   // record the handshakes that edge will complete.
   initial begin
      int   aw_cnt, b_cnt;
      bit   got_aw, got_w, wtog, b_done;
      bit   p_awv, p_awr, p_wv, p_wr, p_br, p_bv;
      logic [7:0]  p_awlen;
      logic [31:0] p_wdata;
      aw_cnt = 0; b_cnt = 0; got_aw = 0; got_w = 0; wtog = 0; b_done = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_br = 0; p_bv = 0;
      p_awlen = '0; p_wdata = '0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0; bus.bid = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            aw_cnt = 0; b_cnt = 0; got_aw = 0; got_w = 0; b_done = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_br = 0; p_bv = 0;
            continue;
         end
         if (p_awv && !p_awr) begin
            chk("aw_valid_held", bus.awvalid, 1);
            chk("aw_len_stable", bus.awlen, p_awlen);
         end
         if (p_wv && !p_wr) begin
            chk("w_valid_held", bus.wvalid, 1);
            chk("w_data_stable", bus.wdata, p_wdata);
         end
         if (p_br && !p_bv) chk("b_ready_held", bus.bready, 1);
         if (bus.bready) chk("b_ready_after_aw", got_aw, 1);

         bus.awready = bus.awvalid && (aw_cnt >= aw_hold);
         if (bus.awvalid) aw_cnt++;
         wtog = !wtog;
         bus.wready = w_toggle ? wtog : 1'b1;
         if (b_done) begin
            bus.bvalid = 0; got_aw = 0; got_w = 0; b_cnt = 0; b_done = 0;
         end else if (got_aw && got_w) begin
            if (b_cnt >= b_delay) begin
               bus.bvalid = 1; bus.bresp = b_resp; bus.bid = b_id;
            end
            b_cnt++;
         end

         if (bus.awvalid && bus.awready) begin
            aw_q.push_back(bus.awlen);
            chk("awaddr", bus.awaddr, ADDR);
            chk("awid", bus.awid, 0);
            chk("awsize", bus.awsize, 2);
            chk("awburst", bus.awburst, 0);
            got_aw = 1; aw_cnt = 0;
         end
         if (bus.wvalid && bus.wready) begin
            wd_q.push_back(bus.wdata);
            wl_q.push_back(bus.wlast);
            chk("wstrb", bus.wstrb, 4'hF);
            if (bus.wlast) begin
               got_w = 1;
               wlast_before_aw = !got_aw;
            end
         end
         if (bus.bvalid && bus.bready) begin
            b_hs_cnt++; b_done = 1;
         end
         p_awv = bus.awvalid; p_awr = bus.awready; p_awlen = bus.awlen;
         p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata;
         p_br = bus.bready; p_bv = bus.bvalid;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Offer n beats and follow the burst to completion. Expected values come
   // from the beat list and the response the slave is told to return.
   task automatic run_burst(string tag, int n, bit use_last, bit fixed,
                            logic [1:0] rsp, logic id);
      logic [31:0] data[$];
      int start, k;
      bit bad;
      for (int i = 0; i < n; i++) data.push_back(fixed ? 32'hA0 + i : $urandom);
      bad = (rsp != 2'b00) || (id != 1'b0);
      if (bad && exp_err < 65535) exp_err++;
      aw_q.delete(); wd_q.delete(); wl_q.delete();
      b_resp = rsp; b_id = id;
      start = b_hs_cnt;
      for (int i = 0; i < n; i++) begin
         input_valid = 1'b1;
         input_data  = data[i];
         input_last  = use_last && (i == n - 1);
         for (k = 0; k < 200 && !input_ready; k++) step();
         if (!input_ready) chk({tag, "_accept_timeout"}, 0, 1);
         step();
      end
      input_valid = 1'b0;
      input_last  = 1'b0;
      chk({tag, "_awvalid_lat"}, bus.awvalid, 1);
      chk({tag, "_wvalid_lat"}, bus.wvalid, 1);
      chk({tag, "_busy"}, busy, 1);
      for (k = 0; k < 200 && b_hs_cnt == start; k++) begin
         chk({tag, "_in_blocked"}, input_ready, 0);
         step();
      end
      if (b_hs_cnt == start) begin
         chk({tag, "_b_timeout"}, 0, 1);
         return;
      end
      chk({tag, "_in_blocked_bhs"}, input_ready, 0);
      step();
      chk({tag, "_in_ready_after_b"}, input_ready, 1);
      chk({tag, "_resp_error"}, resp_error, bad);
      chk({tag, "_error_count"}, error_count, exp_err);
      chk({tag, "_idle"}, busy, 0);
      step();
      chk({tag, "_resp_error_pulse"}, resp_error, 0);
      chk({tag, "_aw_count"}, aw_q.size(), 1);
      if (aw_q.size() > 0) chk({tag, "_awlen"}, aw_q[0], n - 1);
      chk({tag, "_w_count"}, wd_q.size(), n);
      for (int i = 0; i < n && i < wd_q.size(); i++) begin
         chk($sformatf("%s_wdata%0d", tag, i), wd_q[i], data[i]);
         chk($sformatf("%s_wlast%0d", tag, i), wl_q[i], i == n - 1);
      end
   endtask

   initial begin
      int n;
      bit ul;
      logic [1:0] rsp;
      logic id;

      step(); step();
      chk("rst_input_ready", input_ready, 0);
      chk("rst_awvalid", bus.awvalid, 0);
      chk("rst_wvalid", bus.wvalid, 0);
      chk("rst_bready", bus.bready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error_count", error_count, 0);
      chk("rst_resp_error", resp_error, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_input_ready", input_ready, 1);

      run_burst("t1_full", 4, 0, 1, 2'b00, 1'b0);
      run_burst("t2_last", 2, 1, 0, 2'b00, 1'b0);
      run_burst("one_beat", 1, 1, 0, 2'b00, 1'b0);

      aw_hold = 5;
      run_burst("t3_aw_late", 4, 0, 0, 2'b00, 1'b0);
      chk("t3_w_before_aw", wlast_before_aw, 1);
      aw_hold = 0;

      w_toggle = 1; b_delay = 3;
      run_burst("t4_stall", 3, 1, 0, 2'b00, 1'b0);
      w_toggle = 0; b_delay = 0;

      run_burst("t5_slverr", 2, 1, 0, 2'b10, 1'b0);
      run_burst("t5_badid", 4, 0, 0, 2'b00, 1'b1);
      run_burst("t5_okay", 3, 1, 0, 2'b00, 1'b0);
      chk("t5_total_errors", error_count, 2);

      for (int r = 0; r < 10; r++) begin
         n        = $urandom_range(1, BL);
         ul       = (n < BL) ? 1'b1 : 1'($urandom_range(0, 1));
         aw_hold  = $urandom_range(0, 3);
         b_delay  = $urandom_range(0, 3);
         w_toggle = 1'($urandom_range(0, 1));
         rsp      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         id       = ($urandom_range(0, 5) == 0);
         run_burst($sformatf("rnd%0d", r), n, ul, 0, rsp, id);
      end
      aw_hold = 0; b_delay = 0; w_toggle = 0;

      // reset in the middle of a burst: AW stalled, W partly sent
      aw_hold = 20;
      for (int i = 0; i < BL; i++) begin
         input_valid = 1'b1;
         input_data  = $urandom;
         step();
      end
      input_valid = 1'b0;
      chk("t6_in_send", bus.awvalid, 1);
      step();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_awvalid", bus.awvalid, 0);
      chk("t6_rst_wvalid", bus.wvalid, 0);
      chk("t6_rst_bready", bus.bready, 0);
      chk("t6_rst_input_ready", input_ready, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_error_count", error_count, 0);
      exp_err = 0;
      step(); step();
      rst_n = 1'b1;
      aw_hold = 0;
      step();
      chk("t6_fill_ready", input_ready, 1);
      run_burst("t6_after", 4, 0, 0, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
